// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer engine: FSM encoding,
// default geometry and the ceil-div / requantise helpers.
package fc_pkg;

    localparam int FC_DATA_WIDTH   = 8;
    localparam int FC_WEIGHT_WIDTH = 4;
    localparam int FC_PAR          = 20;
    localparam int FC_ACC_WIDTH    = 24;
    localparam int FC_LEN_WIDTH    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fc_state_t;

    // Number of PAR-lane words needed to cover len elements.
    function automatic logic [FC_LEN_WIDTH-1:0] ceil_div(input logic [FC_LEN_WIDTH-1:0] len);
        logic [FC_LEN_WIDTH:0] t;
        t = {1'b0, len} + (FC_LEN_WIDTH+1)'(FC_PAR - 1);
        return FC_LEN_WIDTH'(t / (FC_LEN_WIDTH+1)'(FC_PAR));
    endfunction

    // Round-half-up arithmetic shift, optional ReLU, saturate to DATA_WIDTH.
    function automatic logic signed [FC_DATA_WIDTH-1:0] requant(
        input logic signed [FC_ACC_WIDTH-1:0] acc,
        input logic [3:0]                     sh,
        input logic                           relu
    );
        logic signed [FC_ACC_WIDTH:0] ext;
        logic signed [FC_ACC_WIDTH:0] rnd;
        logic signed [FC_ACC_WIDTH:0] r;
        logic signed [FC_ACC_WIDTH:0] smax;
        logic signed [FC_ACC_WIDTH:0] smin;
        ext  = {acc[FC_ACC_WIDTH-1], acc};
        rnd  = '0;
        if (sh != 4'd0) begin
            rnd[sh - 4'd1] = 1'b1;
        end else begin
            rnd = '0;
        end
        r    = (ext + rnd) >>> sh;
        smax = {{(FC_ACC_WIDTH-FC_DATA_WIDTH+2){1'b0}}, {(FC_DATA_WIDTH-1){1'b1}}};
        smin = ~smax;
        if (relu && r[FC_ACC_WIDTH]) begin
            r = '0;
        end else if (r > smax) begin
            r = smax;
        end else if (r < smin) begin
            r = smin;
        end else begin
            r = r;
        end
        return r[FC_DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/fc_dot_lane_array.sv
// PAR signed multipliers summed into one ACC_WIDTH partial; masked lanes add 0.
module fc_dot_lane_array
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH   = FC_DATA_WIDTH,
    parameter int WEIGHT_WIDTH = FC_WEIGHT_WIDTH,
    parameter int PAR          = FC_PAR,
    parameter int ACC_WIDTH    = FC_ACC_WIDTH
) (
    input  logic [PAR*DATA_WIDTH-1:0]   i_act,
    input  logic [PAR*WEIGHT_WIDTH-1:0] i_weight,
    input  logic [PAR-1:0]              i_mask,
    output logic signed [ACC_WIDTH-1:0] o_sum
);

    localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;

    logic signed [PW-1:0]        w_raw  [PAR];
    logic signed [PW-1:0]        w_prod [PAR];
    logic signed [ACC_WIDTH-1:0] w_sum;

    genvar g;
    generate
        for (g = 0; g < PAR; g++) begin : g_lane
            assign w_raw[g]  = $signed(i_act[g*DATA_WIDTH +: DATA_WIDTH])
                             * $signed(i_weight[g*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
            assign w_prod[g] = i_mask[g] ? w_raw[g] : '0;
        end
    endgenerate

    // Sign-extend each lane product and reduce across all lanes.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < PAR; i++) begin
            w_sum = w_sum + {{(ACC_WIDTH-PW){w_prod[i][PW-1]}}, w_prod[i]};
        end
    end

    assign o_sum = w_sum;

endmodule

// File: rtl/fc_layer_engine.sv
// Run-time configurable FC layer: streams one act/weight word per cycle,
// accumulates per neuron, requantises and writes one neuron per output write.
module fc_layer_engine
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH        = FC_DATA_WIDTH,
    parameter int WEIGHT_WIDTH      = FC_WEIGHT_WIDTH,
    parameter int PAR               = FC_PAR,
    parameter int ACC_WIDTH         = FC_ACC_WIDTH,
    parameter int LEN_WIDTH         = FC_LEN_WIDTH,
    parameter int ACT_ADDR_WIDTH    = 10,
    parameter int WEIGHT_ADDR_WIDTH = 15,
    parameter int OUT_ADDR_WIDTH    = 10
) (
    input  logic                           clk,
    input  logic                           srst,
    input  logic                           start,
    input  logic [LEN_WIDTH-1:0]           in_len,
    input  logic [OUT_ADDR_WIDTH-1:0]      out_len,
    input  logic [WEIGHT_ADDR_WIDTH-1:0]   weight_base,
    input  logic [OUT_ADDR_WIDTH-1:0]      out_base,
    input  logic                           relu_en,
    input  logic [3:0]                     shift,
    output logic [ACT_ADDR_WIDTH-1:0]      act_raddr,
    input  logic [PAR*DATA_WIDTH-1:0]      act_rdata,
    output logic [WEIGHT_ADDR_WIDTH-1:0]   weight_raddr,
    input  logic [PAR*WEIGHT_WIDTH-1:0]    weight_rdata,
    output logic                           out_we,
    output logic [OUT_ADDR_WIDTH-1:0]      out_waddr,
    output logic [DATA_WIDTH-1:0]          out_wdata,
    output logic                           busy,
    output logic                           done
);

    fc_state_t                   r_state;
    logic [LEN_WIDTH-1:0]        r_k_cnt, r_k, r_tail;
    logic [OUT_ADDR_WIDTH-1:0]   r_out_len, r_n, r_out_ptr;
    logic [3:0]                  r_shift;
    logic                        r_relu, r_zero;
    // r_a_* describe the address currently driven, r_d_* the data now arriving.
    logic                        r_a_valid, r_a_first, r_a_last, r_a_final;
    logic                        r_d_valid, r_d_first, r_d_last, r_d_final, r_fin_w;
    logic signed [ACC_WIDTH-1:0] r_acc;

    logic signed [ACC_WIDTH-1:0] w_partial, w_acc_sum;
    logic [PAR-1:0]              w_mask;
    logic [LEN_WIDTH-1:0]        w_k_start, w_tail, w_k_nxt;
    logic                        w_zero;

    assign w_k_start = ceil_div(in_len);
    assign w_tail    = in_len - (w_k_start - LEN_WIDTH'(1)) * LEN_WIDTH'(PAR);
    assign w_zero    = (in_len == '0) || (out_len == '0);
    assign w_k_nxt   = r_k + LEN_WIDTH'(1);
    assign w_acc_sum = r_d_first ? w_partial : (r_acc + w_partial);

    // Lanes past in_len on the final word of a neuron contribute nothing.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PAR; i++) begin
            w_mask[i] = !r_d_last || (LEN_WIDTH'(i) < r_tail);
        end
    end

    fc_dot_lane_array #(
        .DATA_WIDTH   (DATA_WIDTH),
        .WEIGHT_WIDTH (WEIGHT_WIDTH),
        .PAR          (PAR),
        .ACC_WIDTH    (ACC_WIDTH)
    ) u_lanes (
        .i_act    (act_rdata),
        .i_weight (weight_rdata),
        .i_mask   (w_mask),
        .o_sum    (w_partial)
    );

    // Control FSM: config latch, address sequencing, busy/done.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_state      <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            act_raddr    <= '0;
            weight_raddr <= '0;
            r_k_cnt      <= '0;
            r_k          <= '0;
            r_tail       <= '0;
            r_out_len    <= '0;
            r_n          <= '0;
            r_shift      <= 4'd0;
            r_relu       <= 1'b0;
            r_zero       <= 1'b0;
            r_a_valid    <= 1'b0;
            r_a_first    <= 1'b0;
            r_a_last     <= 1'b0;
            r_a_final    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy    <= 1'b1;
                        r_shift <= shift;
                        r_relu  <= relu_en;
                        if (w_zero) begin
                            r_zero  <= 1'b1;
                            r_state <= ST_DRAIN;
                        end else begin
                            r_state      <= ST_RUN;
                            r_k_cnt      <= w_k_start;
                            r_tail       <= w_tail;
                            r_out_len    <= out_len;
                            r_k          <= '0;
                            r_n          <= '0;
                            act_raddr    <= '0;
                            weight_raddr <= weight_base;
                            r_a_valid    <= 1'b1;
                            r_a_first    <= 1'b1;
                            r_a_last     <= (w_k_start == LEN_WIDTH'(1));
                            r_a_final    <= (w_k_start == LEN_WIDTH'(1)) && (out_len == OUT_ADDR_WIDTH'(1));
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (r_a_last) begin
                        if (r_a_final) begin
                            r_state   <= ST_DRAIN;
                            r_a_valid <= 1'b0;
                            r_a_first <= 1'b0;
                            r_a_last  <= 1'b0;
                            r_a_final <= 1'b0;
                        end else begin
                            r_n          <= r_n + OUT_ADDR_WIDTH'(1);
                            r_k          <= '0;
                            act_raddr    <= '0;
                            weight_raddr <= weight_raddr + WEIGHT_ADDR_WIDTH'(1);
                            r_a_first    <= 1'b1;
                            r_a_last     <= (r_k_cnt == LEN_WIDTH'(1));
                            r_a_final    <= (r_k_cnt == LEN_WIDTH'(1))
                                         && (r_n + OUT_ADDR_WIDTH'(1) == r_out_len - OUT_ADDR_WIDTH'(1));
                        end
                    end else begin
                        r_k          <= w_k_nxt;
                        act_raddr    <= ACT_ADDR_WIDTH'(w_k_nxt);
                        weight_raddr <= weight_raddr + WEIGHT_ADDR_WIDTH'(1);
                        r_a_first    <= 1'b0;
                        r_a_last     <= (w_k_nxt == r_k_cnt - LEN_WIDTH'(1));
                        r_a_final    <= (w_k_nxt == r_k_cnt - LEN_WIDTH'(1))
                                     && (r_n == r_out_len - OUT_ADDR_WIDTH'(1));
                    end
                end
                ST_DRAIN: begin
                    if (r_fin_w || r_zero) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_zero  <= 1'b0;
                    end else begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Datapath: accumulate arriving words, requantise and write on each neuron's last word.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_d_valid <= 1'b0;
            r_d_first <= 1'b0;
            r_d_last  <= 1'b0;
            r_d_final <= 1'b0;
            r_fin_w   <= 1'b0;
            r_acc     <= '0;
            r_out_ptr <= '0;
            out_we    <= 1'b0;
            out_waddr <= '0;
            out_wdata <= '0;
        end else begin
            r_d_valid <= r_a_valid;
            r_d_first <= r_a_first;
            r_d_last  <= r_a_last;
            r_d_final <= r_a_final;
            if ((r_state == ST_IDLE) && start) begin
                r_out_ptr <= out_base;
            end else if (r_d_valid && r_d_last) begin
                r_out_ptr <= r_out_ptr + OUT_ADDR_WIDTH'(1);
            end else begin
                r_out_ptr <= r_out_ptr;
            end
            if (r_d_valid) begin
                r_acc <= w_acc_sum;
            end else begin
                r_acc <= r_acc;
            end
            if (r_d_valid && r_d_last) begin
                out_we    <= 1'b1;
                out_waddr <= r_out_ptr;
                out_wdata <= requant(w_acc_sum, r_shift, r_relu);
                r_fin_w   <= r_d_final;
            end else begin
                out_we    <= 1'b0;
                r_fin_w   <= 1'b0;
            end
        end
    end

endmodule
